// File: rtl/button_pkg.sv
// Shared types for the push-button conditioning logic.
package button_pkg;

    // Debounce FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StArming    = 2'd1,
        StHeld      = 2'd2,
        StDisarming = 2'd3
    } btn_state_e;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with synchronous clear for asynchronous input pins.
module sync_2ff (
    input  logic clk_i,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture; clear forces the "inactive" level.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizer, debounce FSM, press/release/long-press
// strobes and a stretched reset request for "hold button to reboot".
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_BITS = 16,
    parameter int unsigned LONG_BITS     = 22,
    parameter int unsigned STRETCH_BITS  = 4,
    parameter bit          ACTIVE_LOW    = 1'b0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BTN,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic reset_req
);

    localparam logic [DEBOUNCE_BITS-1:0] DcntMax  = '1;
    // Last value before the long-press threshold; the MSB of lcnt marks "already fired".
    localparam logic [LONG_BITS:0]       LcntMax  = {1'b0, {LONG_BITS{1'b1}}};
    localparam logic [STRETCH_BITS-1:0]  ScntInit = '1;

    logic                     btn_norm;
    logic                     btn_s;

    btn_state_e               state_q, state_d;
    logic [DEBOUNCE_BITS-1:0] dcnt_q, dcnt_d;
    logic [LONG_BITS:0]       lcnt_q, lcnt_d;
    logic [STRETCH_BITS-1:0]  scnt_q, scnt_d;

    logic pressed_q, pressed_d;
    logic press_q, press_d;
    logic release_q, release_d;
    logic long_q, long_d;
    logic req_q, req_d;
    logic stretch_busy;

    // Normalise polarity so that 1 always means "pressed".
    assign btn_norm = BTN ^ ACTIVE_LOW;

    sync_2ff u_sync (
        .clk_i (CLK),
        .clr_i (RESET),
        .d_i   (btn_norm),
        .q_o   (btn_s)
    );

    // FSM state and debounce counter register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Debounce next-state: the counter restarts on every entry to a qualifying state.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            StIdle: begin
                if (btn_s) begin
                    state_d = StArming;
                    dcnt_d  = '0;
                end
            end
            StArming: begin
                if (!btn_s) begin
                    state_d = StIdle;
                end else if (dcnt_q != DcntMax) begin
                    dcnt_d = dcnt_q + 1'b1;
                end else begin
                    state_d = StHeld;
                end
            end
            StHeld: begin
                if (!btn_s) begin
                    state_d = StDisarming;
                    dcnt_d  = '0;
                end
            end
            StDisarming: begin
                if (btn_s) begin
                    state_d = StHeld;
                end else if (dcnt_q != DcntMax) begin
                    dcnt_d = dcnt_q + 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                dcnt_d  = '0;
            end
        endcase
    end

    // Output next-state: strobes, held level, long-press counter and reset stretch.
    always_comb begin
        press_d   = (state_q == StArming) && btn_s && (dcnt_q == DcntMax);
        release_d = (state_q == StDisarming) && !btn_s && (dcnt_q == DcntMax);

        pressed_d = pressed_q;
        if (press_d) begin
            pressed_d = 1'b1;
        end else if (release_d) begin
            pressed_d = 1'b0;
        end

        // Holding lcnt at the threshold while a stretch is in flight keeps a second
        // long strobe from landing inside the current reset request.
        stretch_busy = long_q || req_q;
        lcnt_d       = lcnt_q;
        long_d       = 1'b0;
        if (press_d) begin
            lcnt_d = '0;
        end else if ((state_q == StHeld) && btn_s && !lcnt_q[LONG_BITS]) begin
            if (lcnt_q != LcntMax) begin
                lcnt_d = lcnt_q + 1'b1;
            end else if (!stretch_busy) begin
                lcnt_d = lcnt_q + 1'b1;
                long_d = 1'b1;
            end
        end

        req_d  = req_q;
        scnt_d = scnt_q;
        if (long_q) begin
            req_d  = 1'b1;
            scnt_d = ScntInit;
        end else if (req_q) begin
            if (scnt_q == '0) begin
                req_d = 1'b0;
            end else begin
                scnt_d = scnt_q - 1'b1;
            end
        end
    end

    // Output and counter registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            req_q     <= 1'b0;
            lcnt_q    <= '0;
            scnt_q    <= '0;
        end else begin
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            req_q     <= req_d;
            lcnt_q    <= lcnt_d;
            scnt_q    <= scnt_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign reset_req     = req_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: DUT 0 is active-high, DUT 1 is active-low.
// Expected strobe/edge events are queued with their due cycle and matched by a monitor.
module tb_button_conditioner;

    localparam int PressLat = 18;  // clean BTN step to press/release strobe
    localparam int LongLat  = 64;  // press_pulse to long_pulse
    localparam int ReqLen   = 8;   // reset_req width

    typedef enum int {EvPress, EvRelease, EvLong, EvReqRise, EvReqFall} ev_e;
    typedef struct {
        int  dut;
        ev_e kind;
        int  cyc;
    } exp_t;
    typedef struct {
        bit  lvl;
        int  len;
        bit  has_ev;
        ev_e ev;
        bit  exp_pressed;
    } seg_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    logic       CLK = 1'b0;
    logic [1:0] rst;
    logic [1:0] btn;
    logic [1:0] pressed_v, press_v, rel_v, long_v, req_v;
    logic [1:0] req_prev = '0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    button_conditioner #(
        .DEBOUNCE_BITS (4),
        .LONG_BITS     (6),
        .STRETCH_BITS  (3),
        .ACTIVE_LOW    (1'b0)
    ) dut0 (
        .CLK           (CLK),
        .RESET         (rst[0]),
        .BTN           (btn[0]),
        .pressed       (pressed_v[0]),
        .press_pulse   (press_v[0]),
        .release_pulse (rel_v[0]),
        .long_pulse    (long_v[0]),
        .reset_req     (req_v[0])
    );

    button_conditioner #(
        .DEBOUNCE_BITS (4),
        .LONG_BITS     (6),
        .STRETCH_BITS  (3),
        .ACTIVE_LOW    (1'b1)
    ) dut1 (
        .CLK           (CLK),
        .RESET         (rst[1]),
        .BTN           (btn[1]),
        .pressed       (pressed_v[1]),
        .press_pulse   (press_v[1]),
        .release_pulse (rel_v[1]),
        .long_pulse    (long_v[1]),
        .reset_req     (req_v[1])
    );

    task automatic push(input int d, input ev_e k, input int c);
        exp_t e;
        e.dut  = d;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Match an observed event against the head of the scoreboard.
    task automatic take(input int d, input ev_e k);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: dut%0d got %s at cycle %0d, required none",
                     d, k.name(), cyc);
        end else begin
            e = exp_q[0];
            if (e.dut == d && e.kind == k && e.cyc == cyc) begin
                void'(exp_q.pop_front());
            end else begin
                failures++;
                $display("FAIL event_order: dut%0d got %s at cycle %0d, required dut%0d %s at cycle %0d",
                         d, k.name(), cyc, e.dut, e.kind.name(), e.cyc);
                if (e.cyc <= cyc) void'(exp_q.pop_front());
            end
        end
    endtask

    // Monitor: sample 1 time unit after each active edge.
    always @(posedge CLK) begin
        #1;
        while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_event: dut%0d got nothing, required %s at cycle %0d",
                     exp_q[0].dut, exp_q[0].kind.name(), exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        for (int d = 0; d < 2; d++) begin
            if (press_v[d] === 1'b1) take(d, EvPress);
            if (rel_v[d] === 1'b1) take(d, EvRelease);
            if (long_v[d] === 1'b1) take(d, EvLong);
            if (req_v[d] === 1'b1 && req_prev[d] !== 1'b1) take(d, EvReqRise);
            if (req_v[d] !== 1'b1 && req_prev[d] === 1'b1) take(d, EvReqFall);
            req_prev[d] = req_v[d];
        end
    end

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic check_zero(input string name, input int d);
        logic [4:0] v;
        v = {pressed_v[d], press_v[d], rel_v[d], long_v[d], req_v[d]};
        checks++;
        if (v !== 5'b0) begin
            failures++;
            $display("FAIL %s: dut%0d outputs got %b, required 00000", name, d, v);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drive BTN at a falling edge; returns the rising edge that first samples it.
    task automatic drive(input int d, input logic lvl, output int k);
        @(negedge CLK);
        btn[d] = lvl;
        k = cyc + 1;
    endtask

    task automatic do_reset(input int d, input logic idle);
        @(negedge CLK);
        rst[d] = 1'b1;
        btn[d] = idle;
        run(2);
        @(negedge CLK);
        rst[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        seg_t segs[10];
        int   k;
        int   p;
        int   l;

        // Bounce three times, then a clean press, a short dip, and a real release.
        segs = '{
            '{1'b1, 5, 1'b0, EvPress, 1'b0},
            '{1'b0, 3, 1'b0, EvPress, 1'b0},
            '{1'b1, 5, 1'b0, EvPress, 1'b0},
            '{1'b0, 3, 1'b0, EvPress, 1'b0},
            '{1'b1, 5, 1'b0, EvPress, 1'b0},
            '{1'b0, 3, 1'b0, EvPress, 1'b0},
            '{1'b1, 40, 1'b1, EvPress, 1'b1},
            '{1'b0, 10, 1'b0, EvPress, 1'b1},
            '{1'b1, 30, 1'b0, EvPress, 1'b1},
            '{1'b0, 40, 1'b1, EvRelease, 1'b0}
        };

        // Reset held with the button pressed (DUT 1 idles released at BTN=1).
        rst = 2'b11;
        btn = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check_zero("t1_reset_dut0", 0);
            check_zero("t1_reset_dut1", 1);
        end
        @(negedge CLK);
        rst = 2'b00;
        push(0, EvPress, cyc + 1 + PressLat);
        run(30);
        check_bit("t1_pressed", pressed_v[0], 1'b1);

        // Bounce / dip / release table.
        do_reset(0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(0, segs[i].lvl, k);
            if (segs[i].has_ev) push(0, segs[i].ev, k + PressLat);
            run(segs[i].len);
            check_bit($sformatf("t23_seg%0d_pressed", i), pressed_v[0], segs[i].exp_pressed);
        end

        // Long hold: one long strobe, then an 8-cycle reset request.
        do_reset(0, 1'b0);
        drive(0, 1'b1, k);
        p = k + PressLat;
        l = p + LongLat;
        push(0, EvPress, p);
        push(0, EvLong, l);
        push(0, EvReqRise, l + 1);
        push(0, EvReqFall, l + 1 + ReqLen);
        run(500);
        check_bit("t4_long_pressed", pressed_v[0], 1'b1);
        check_bit("t4_req_done", req_v[0], 1'b0);
        drive(0, 1'b0, k);
        push(0, EvRelease, k + PressLat);
        run(30);
        check_bit("t4_released", pressed_v[0], 1'b0);

        // Release during the stretch must not shorten it.
        drive(0, 1'b1, k);
        p = k + PressLat;
        l = p + LongLat;
        push(0, EvPress, p);
        push(0, EvLong, l);
        push(0, EvReqRise, l + 1);
        push(0, EvReqFall, l + 1 + ReqLen);
        run(l + 3 - cyc);
        check_bit("t4b_req_mid", req_v[0], 1'b1);
        drive(0, 1'b0, k);
        push(0, EvRelease, k + PressLat);
        run(30);
        check_bit("t4b_released", pressed_v[0], 1'b0);

        // Reset in the third cycle of reset_req clears everything, no release strobe.
        do_reset(0, 1'b0);
        drive(0, 1'b1, k);
        p = k + PressLat;
        l = p + LongLat;
        push(0, EvPress, p);
        push(0, EvLong, l);
        push(0, EvReqRise, l + 1);
        run(l + 3 - cyc);
        @(negedge CLK);
        rst[0] = 1'b1;
        btn[0] = 1'b0;
        push(0, EvReqFall, cyc + 1);
        run(1);
        check_zero("t6_reset_clear", 0);
        @(negedge CLK);
        rst[0] = 1'b0;
        run(40);
        check_bit("t6_pressed_after", pressed_v[0], 1'b0);

        // Active-low DUT: it has idled at BTN=1 all along; now press and release it.
        drive(1, 1'b0, k);
        push(1, EvPress, k + PressLat);
        run(30);
        check_bit("t5_al_pressed", pressed_v[1], 1'b1);
        drive(1, 1'b1, k);
        push(1, EvRelease, k + PressLat);
        run(30);
        check_bit("t5_al_released", pressed_v[1], 1'b0);

        run(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
